// File: rtl/mux_arb_n_1.sv
// N-input registered arbitrating multiplexer with valid/ready on every channel.
// Define MUX_ARB_RR_EN for round-robin arbitration; otherwise the lowest-index requester wins.
module mux_arb_n_1 #(
    parameter int WIDTH = 5,
    parameter int N     = 4,
    parameter int SW    = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N*WIDTH-1:0]   X,
    input  logic [N-1:0]         in_valid,
    output logic [N-1:0]         in_ready,
    output logic [WIDTH-1:0]     Y,
    output logic [SW-1:0]        SEL,
    output logic                 out_valid,
    input  logic                 out_ready
);

    if ((N < 2) || (N > 16) || ((2 ** SW) < N)) begin : g_param_check
        $error("mux_arb_n_1: N must be 2..16 and 2**SW must cover N");
    end

    logic                 load_s;
    logic                 any_s;
    logic [N-1:0]         grant_s;
    logic [SW-1:0]        win_s;
    logic [WIDTH-1:0]     win_data_s;

    logic [WIDTH-1:0]     y_q;
    logic [WIDTH-1:0]     y_d;
    logic [SW-1:0]        sel_q;
    logic [SW-1:0]        sel_d;
    logic                 valid_q;
    logic                 valid_d;

`ifdef MUX_ARB_RR_EN
    logic [SW-1:0]        ptr_q;
    logic [SW-1:0]        ptr_d;
`endif

    assign load_s = !valid_q || out_ready;

    // Arbitration: first requester found, scanning upward from the search start.
    always_comb begin
        int idx_v;
        idx_v      = 0;
        any_s      = 1'b0;
        grant_s    = '0;
        win_s      = '0;
        win_data_s = '0;
        for (int k = 0; k < N; k++) begin
`ifdef MUX_ARB_RR_EN
            // Wrap on N, not on 2**SW, so unused index codes are never visited.
            idx_v = int'(ptr_q) + k;
            if (idx_v >= N) begin
                idx_v = idx_v - N;
            end else begin
                idx_v = idx_v;
            end
`else
            idx_v = k;
`endif
            if (!any_s && in_valid[idx_v]) begin
                any_s          = 1'b1;
                grant_s[idx_v] = 1'b1;
                win_s          = SW'(idx_v);
                win_data_s     = X[idx_v*WIDTH +: WIDTH];
            end else begin
                any_s = any_s;
            end
        end
    end

    // Handshake back to producers; nothing is accepted while reset is held.
    always_comb begin
        if (rst_n && load_s) begin
            in_ready = grant_s;
        end else begin
            in_ready = '0;
        end
    end

    // Output-stage next state: load winner, go idle, or hold under backpressure.
    always_comb begin
        y_d     = y_q;
        sel_d   = sel_q;
        valid_d = valid_q;
`ifdef MUX_ARB_RR_EN
        ptr_d   = ptr_q;
`endif
        if (load_s) begin
            if (any_s) begin
                y_d     = win_data_s;
                sel_d   = win_s;
                valid_d = 1'b1;
`ifdef MUX_ARB_RR_EN
                if (win_s == SW'(N - 1)) begin
                    ptr_d = '0;
                end else begin
                    ptr_d = win_s + SW'(1);
                end
`endif
            end else begin
                valid_d = 1'b0;
            end
        end else begin
            valid_d = valid_q;
        end
    end

    // Output stage registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_q     <= '0;
            sel_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            y_q     <= y_d;
            sel_q   <= sel_d;
            valid_q <= valid_d;
        end
    end

`ifdef MUX_ARB_RR_EN
    // Round-robin search start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`endif

    assign Y         = y_q;
    assign SEL       = sel_q;
    assign out_valid = valid_q;

endmodule

// File: tb/tb_mux_arb_n_1.sv
// Scoreboard bench for mux_arb_n_1: a 4-channel and a 3-channel instance share random stimulus.
module tb_mux_arb_n_1;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic [19:0] x     = 20'h0;
    logic [3:0]  vld   = 4'h0;
    logic        rdy   = 1'b0;

    logic [3:0]  in_rdy4;
    logic [4:0]  y4;
    logic [1:0]  sel4;
    logic        ov4;
    logic [2:0]  in_rdy3;
    logic [4:0]  y3;
    logic [1:0]  sel3;
    logic        ov3;

    int checks = 0;
    int errors = 0;

    logic [6:0] q4[$];
    logic [6:0] q3[$];
    int         ptr4  = 0;
    int         ptr3  = 0;
    bit         busy4 = 1'b0;
    bit         busy3 = 1'b0;

    always #5 clk = ~clk;

    mux_arb_n_1 #(.WIDTH(5), .N(4), .SW(2)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .X(x), .in_valid(vld), .in_ready(in_rdy4),
        .Y(y4), .SEL(sel4), .out_valid(ov4), .out_ready(rdy)
    );

    mux_arb_n_1 #(.WIDTH(5), .N(3), .SW(2)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .X(x[14:0]), .in_valid(vld[2:0]), .in_ready(in_rdy3),
        .Y(y3), .SEL(sel3), .out_valid(ov3), .out_ready(rdy)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Channel that the arbitration rules award, or -1 if nobody requests.
    function automatic int pick(input int n, input logic [3:0] v, input int start);
        for (int k = 0; k < n; k++) begin
            int c;
            c = (start + k) % n;
            if (v[c]) return c;
        end
        return -1;
    endfunction

    function automatic int next_ptr(input int w, input int n);
`ifdef MUX_ARB_RR_EN
        return (w + 1) % n;
`else
        return 0 * (w + n);
`endif
    endfunction

    // Predict the coming edge for both instances and queue accepted beats.
    task automatic model_cycle();
        int         w;
        logic [3:0] exp_rdy;
        bit         load;

        load = !busy4 || rdy;
        w = load ? pick(4, vld, ptr4) : -1;
        exp_rdy = 4'h0;
        if (w >= 0) exp_rdy[w] = 1'b1;
        chk("in_ready_n4", 32'(in_rdy4), 32'(exp_rdy));
        if (load) begin
            if (w >= 0) begin
                q4.push_back({x[w*5 +: 5], 2'(w)});
                busy4 = 1'b1;
                ptr4  = next_ptr(w, 4);
            end else begin
                busy4 = 1'b0;
            end
        end

        load = !busy3 || rdy;
        w = load ? pick(3, {1'b0, vld[2:0]}, ptr3) : -1;
        exp_rdy = 4'h0;
        if (w >= 0) exp_rdy[w] = 1'b1;
        chk("in_ready_n3", 32'(in_rdy3), 32'(exp_rdy));
        if (load) begin
            if (w >= 0) begin
                q3.push_back({x[w*5 +: 5], 2'(w)});
                busy3 = 1'b1;
                ptr3  = next_ptr(w, 3);
            end else begin
                busy3 = 1'b0;
            end
        end
    endtask

    task automatic cycle(input logic [3:0] v, input logic r, input logic [19:0] xv);
        @(posedge clk);
        #1;
        vld = v;
        rdy = r;
        x   = xv;
        @(negedge clk);
        #1;
        model_cycle();
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_out_valid"}, 32'({ov4, ov3}), 32'h0);
        chk({tag, "_Y"},         32'({y4, y3}), 32'h0);
        chk({tag, "_SEL"},       32'({sel4, sel3}), 32'h0);
        chk({tag, "_in_ready"},  32'({in_rdy4, in_rdy3}), 32'h0);
    endtask

    // Monitor: every presented beat must match the oldest accepted beat.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("occupancy_n4", 32'(q4.size()), 32'(ov4));
            if (ov4 && q4.size() > 0) begin
                chk("beat_n4", 32'({y4, sel4}), 32'(q4[0]));
                if (rdy) void'(q4.pop_front());
            end
            chk("occupancy_n3", 32'(q3.size()), 32'(ov3));
            if (ov3 && q3.size() > 0) begin
                chk("beat_n3", 32'({y3, sel3}), 32'(q3[0]));
                if (rdy) void'(q3.pop_front());
            end
        end
    end

    initial begin
        logic [19:0] xv;

        vld = 4'b1111;
        repeat (2) @(posedge clk);
        #2;
        check_reset_outputs("por");
        @(posedge clk);
        #2;
        vld   = 4'h0;
        rst_n = 1'b1;

        // Single requester on channel 2.
        xv = 20'($urandom);
        xv[14:10] = 5'h15;
        cycle(4'b0100, 1'b1, xv);
        cycle(4'b0000, 1'b1, 20'($urandom));

        // Everyone requesting with the consumer always ready.
        repeat (8) cycle(4'b1111, 1'b1, 20'($urandom));

        // Backpressure then resume.
        cycle(4'b0011, 1'b1, 20'($urandom));
        repeat (3) cycle(4'b0011, 1'b0, 20'($urandom));
        repeat (4) cycle(4'b0011, 1'b1, 20'($urandom));

        // Drain and refill, then go idle.
        repeat (2) cycle(4'b0010, 1'b1, 20'($urandom));
        repeat (2) cycle(4'b0000, 1'b1, 20'($urandom));

        // Top-channel winner then a low request exercises pointer wrap.
        cycle(4'b0100, 1'b1, 20'($urandom));
        cycle(4'b0011, 1'b1, 20'($urandom));
        cycle(4'b1000, 1'b1, 20'($urandom));
        cycle(4'b0011, 1'b1, 20'($urandom));

        // Reset while a beat is stuck under backpressure.
        repeat (2) cycle(4'b0001, 1'b0, 20'($urandom));
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        q4.delete();
        q3.delete();
        busy4 = 1'b0;
        busy3 = 1'b0;
        ptr4  = 0;
        ptr3  = 0;
        #1;
        check_reset_outputs("midrst");
        @(posedge clk);
        #2;
        vld   = 4'h0;
        rst_n = 1'b1;
        cycle(4'b1000, 1'b1, 20'($urandom));
        cycle(4'b0000, 1'b1, 20'($urandom));

        // Random traffic with random backpressure.
        for (int i = 0; i < 400; i++) begin
            cycle(4'($urandom), ($urandom_range(0, 3) != 0), 20'($urandom));
        end
        repeat (3) cycle(4'b0000, 1'b1, 20'($urandom));

        chk("final_drain_n4", 32'(q4.size()), 32'h0);
        chk("final_drain_n3", 32'(q3.size()), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
